alu_seg_arbiter: RTL and testbench

ALU_SEG_ARBITER -- requirements
Module: alu_seg_arbiter

---
 rtl/alu_seg_arb_pkg.sv | 21 ++
 rtl/alu_seg_unit.sv | 33 +++
 rtl/alu_seg_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_seg_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seg_arb_pkg.sv
// Shared constants for alu_seg_arbiter: opcodes, FSM states and the hex-to-segment table.
package alu_seg_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Segment order gfedcba, active-high; index is the hex digit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/alu_seg_unit.sv
// Combinational 2-bit-opcode ALU with carry/borrow and a hex segment decoder
// on the low nibble of the result (WIDTH must be at least 4).
module alu_seg_unit
  import alu_seg_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [6:0]       seg
);

  // One extra bit holds add carry-out or subtract borrow.
  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      default: ext = {1'b0, a | b};
    endcase
  end

  assign result = ext[WIDTH-1:0];
  assign carry  = ext[WIDTH];
  assign seg    = SEG_TABLE[ext[3:0]];

endmodule

// File: rtl/alu_seg_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU whose result is shown on a
// 7-segment display. Define ALU_SEG_ARB_CARRY_DP_EN to drive the dp with carry.
module alu_seg_arbiter
  import alu_seg_arb_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [1:0]       op0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [1:0]       op1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic [7:0]       seg_o,
  output logic             busy_o
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state, state_next;
  logic [CW-1:0]    hold_cnt, cnt_next;
  logic             ptr, owner, win;
  logic             grant_en, exec_en;
  logic [1:0]       gnt_next, done_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [6:0]       alu_seg;
  logic             dp;

  alu_seg_unit #(.WIDTH(WIDTH)) u_unit (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry),
    .seg    (alu_seg)
  );

`ifdef ALU_SEG_ARB_CARRY_DP_EN
  assign dp = alu_carry;
`else
  assign dp = 1'b0;
`endif

  // The pointer only matters on contention; a lone requester always wins.
  assign win    = (req_i == 2'b11) ? ptr : req_i[1];
  assign busy_o = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = hold_cnt;
    gnt_next   = '0;
    done_next  = '0;
    grant_en   = 1'b0;
    exec_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_i) begin
          grant_en   = 1'b1;
          gnt_next   = win ? 2'b10 : 2'b01;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_en   = 1'b1;
        done_next = owner ? 2'b10 : 2'b01;
        if (HOLD_CYCLES == 0) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_HOLD;
          cnt_next   = CW'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) state_next = ST_IDLE;
        else                cnt_next   = hold_cnt - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      gnt_o    <= '0;
      done_o   <= '0;
      result_o <= '0;
      carry_o  <= 1'b0;
      seg_o    <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= cnt_next;
      gnt_o    <= gnt_next;
      done_o   <= done_next;
      if (grant_en) begin
        owner <= win;
        ptr   <= ~win;
        a_q   <= win ? a1_i  : a0_i;
        b_q   <= win ? b1_i  : b0_i;
        op_q  <= win ? op1_i : op0_i;
      end
      if (exec_en) begin
        result_o <= alu_result;
        carry_o  <= alu_carry;
        seg_o    <= {dp, alu_seg};
      end
    end
  end

endmodule

// File: tb/tb_alu_seg_arbiter.sv
// Scoreboard bench for alu_seg_arbiter (default HOLD_CYCLES plus a HOLD_CYCLES=0 copy).
module tb_alu_seg_arbiter;

  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req_z;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;

  logic [1:0] gnt_o, done_o, gnt_z, done_z;
  logic [3:0] result_o, res_z;
  logic       carry_o, busy_o, carry_z, busy_z;
  logic [7:0] seg_o, seg_z;

  always #5 clk = ~clk;

  alu_seg_arbiter #(.WIDTH(4), .HOLD_CYCLES(H)) u_dut (
    .clk(clk), .rst(rst), .req_i(req),
    .a0_i(a0), .b0_i(b0), .op0_i(op0), .a1_i(a1), .b1_i(b1), .op1_i(op1),
    .gnt_o(gnt_o), .done_o(done_o), .result_o(result_o), .carry_o(carry_o),
    .seg_o(seg_o), .busy_o(busy_o)
  );

  alu_seg_arbiter #(.WIDTH(4), .HOLD_CYCLES(0)) u_dut_h0 (
    .clk(clk), .rst(rst), .req_i(req_z),
    .a0_i(a0), .b0_i(b0), .op0_i(op0), .a1_i(a1), .b1_i(b1), .op1_i(op1),
    .gnt_o(gnt_z), .done_o(done_z), .result_o(res_z), .carry_o(carry_z),
    .seg_o(seg_z), .busy_o(busy_z)
  );

  typedef struct { int cyc; logic [1:0] gnt; } gnt_item_t;
  typedef struct { int cyc; logic [1:0] done; logic [3:0] res; logic carry; logic [7:0] seg; } done_item_t;

  gnt_item_t  gnt_q[$];
  done_item_t done_q[$];
  gnt_item_t  mon_g;
  done_item_t mon_d;
  int         gz_times[$];

  int         vectors = 0, miscompares = 0;
  int         cyc = 0;
  int         free_edge = 0, last_grant = -100, ptr_m = 0;
  logic [7:0] disp_m = '0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [6:0] hex_seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
     12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decide what the arbiter does at the coming edge from
  // the requests, then schedule the expected grant and completion.
  task automatic apply(input logic [1:0] r, input logic [3:0] xa0, input logic [3:0] xb0,
                       input logic [1:0] xo0, input logic [3:0] xa1, input logic [3:0] xb1,
                       input logic [1:0] xo1);
    int e, w, a, b, o, res;
    logic c, dpv;
    gnt_item_t gi;
    done_item_t di;
    req = r; a0 = xa0; b0 = xb0; op0 = xo0; a1 = xa1; b1 = xb1; op1 = xo1;
    e = cyc + 1;
    if (e >= free_edge && r != 2'b00) begin
      w = (r == 2'b11) ? ptr_m : ((r == 2'b10) ? 1 : 0);
      ptr_m = 1 - w;
      a = (w == 1) ? int'(xa1) : int'(xa0);
      b = (w == 1) ? int'(xb1) : int'(xb0);
      o = (w == 1) ? int'(xo1) : int'(xo0);
      case (o)
        0: begin res = (a + b) % 16; c = (a + b) > 15; end
        1: begin res = (a - b + 16) % 16; c = (a < b); end
        2: begin res = a & b; c = 1'b0; end
        default: begin res = a | b; c = 1'b0; end
      endcase
`ifdef ALU_SEG_ARB_CARRY_DP_EN
      dpv = c;
`else
      dpv = 1'b0;
`endif
      gi.cyc = e;     gi.gnt = (w == 1) ? 2'b10 : 2'b01;
      di.cyc = e + 1; di.done = gi.gnt; di.res = 4'(res); di.carry = c;
      di.seg = {dpv, hex_seg(res)};
      gnt_q.push_back(gi);
      done_q.push_back(di);
      last_grant = e;
      free_edge  = e + 2 + H;
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 2'b00);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req = 2'b00; req_z = 2'b00;
    gnt_q.delete(); done_q.delete();
    ptr_m = 0; disp_m = '0; last_grant = -100; free_edge = 0;
    repeat (n) begin @(negedge clk); #1; end
    check("rst_gnt",    32'(gnt_o),    0);
    check("rst_done",   32'(done_o),   0);
    check("rst_busy",   32'(busy_o),   0);
    check("rst_result", 32'(result_o), 0);
    check("rst_carry",  32'(carry_o),  0);
    check("rst_seg",    32'(seg_o),    0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
      mon_g = gnt_q.pop_front();
      check("gnt", 32'(gnt_o), 32'(mon_g.gnt));
    end else begin
      check("gnt_unexpected", 32'(gnt_o), 0);
    end
    if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
      mon_d = done_q.pop_front();
      check("done",   32'(done_o),   32'(mon_d.done));
      check("result", 32'(result_o), 32'(mon_d.res));
      check("carry",  32'(carry_o),  32'(mon_d.carry));
      check("seg",    32'(seg_o),    32'(mon_d.seg));
      disp_m = mon_d.seg;
    end else begin
      check("done_unexpected", 32'(done_o), 0);
      if (!rst) check("seg_hold", 32'(seg_o), 32'(disp_m));
    end
    if (!rst) check("busy", 32'(busy_o), 32'(cyc >= last_grant && cyc <= last_grant + H));
    check("gnt_done_excl", 32'((|gnt_o) & (|done_o)), 0);
    if (|gnt_z) gz_times.push_back(cyc);
  end

  initial begin
    rst = 1'b1; req = 2'b00; req_z = 2'b00;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    @(negedge clk); #1;

    do_reset(2);
    idle(3);
    check("idle_seg",  32'(seg_o),  0);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_gnt",  32'(gnt_o),  0);

    apply(2'b01, 4'h9, 4'h8, 2'b00, 4'h0, 4'h0, 2'b00);
    idle(6);

    do_reset(2);
    repeat (6) apply(2'b11, 4'h3, 4'h5, 2'b01, 4'hA, 4'h5, 2'b11);
    idle(6);

    apply(2'b01, 4'h6, 4'h2, 2'b10, 4'h0, 4'h0, 2'b00);
    idle(1);
    repeat (2) apply(2'b10, 4'h0, 4'h0, 2'b00, 4'h7, 4'h7, 2'b00);
    idle(5);

    do_reset(2);
    idle(1);
    apply(2'b01, 4'hF, 4'h1, 2'b00, 4'h0, 4'h0, 2'b00);
    do_reset(2);
    idle(4);

    do_reset(2);
    repeat (400) apply(2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    idle(8);

    gz_times.delete();
    req_z = 2'b11;
    idle(9);
    req_z = 2'b00;
    idle(3);
    check("h0_grant_count", 32'(gz_times.size()), 5);
    for (int i = 1; i < gz_times.size(); i++)
      check("h0_spacing", 32'(gz_times[i] - gz_times[i-1]), 2);

    check("queue_drain", 32'(gnt_q.size() + done_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
